// File: rtl/seq_decorr_pkg.sv
// Shared constants and helpers for the seq_decorr stream decorrelator and
// the 8-bit Fibonacci LFSR used by stochastic-computing stream generators.
package seq_decorr_pkg;

  localparam int LFSR_W = 8;
  // Taps at bits 7,5,4,3: maximal-length 255-state sequence, never reaches 0.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  // Alternating 0/1 fill (entry i holds i[0]) so the buffer starts at value 0.5.
  function automatic logic [15:0] init_buf(input int depth);
    logic [15:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < depth) b[i] = i[0];
    end
    return b;
  endfunction

endpackage

// File: rtl/sc_lfsr8.sv
// 8-bit Fibonacci LFSR (shift left) that advances only while en is high.
module sc_lfsr8
  import seq_decorr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_decorr.sv
// Sequential decorrelator: x is delayed one cycle, y is shuffled through an
// LFSR-addressed buffer. Optional counters enabled by SEQ_DECORR_STATS_EN.
module seq_decorr
  import seq_decorr_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [7:0]  SEED  = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        x,
  input  logic        y,
  output logic        x_dec_r,
  output logic        y_dec_r
`ifdef SEQ_DECORR_STATS_EN
  ,
  output logic [15:0] ones_in_cnt,
  output logic [15:0] ones_out_cnt
`endif
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH-1:0] BUF_INIT = DEPTH'(init_buf(DEPTH));
  // An all-zero seed would lock the LFSR, so it is replaced with 8'h01.
  localparam logic [7:0]       SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  logic [LFSR_W-1:0] lfsr_q;
  logic [IDX_W-1:0]  idx;
  logic [DEPTH-1:0]  buf_q, buf_d;
  logic              x_q, x_d, y_q, y_d;

  sc_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .seed  (SEED_EFF),
    .q     (lfsr_q)
  );

  assign idx = IDX_W'(lfsr_q % 8'(DEPTH));

  // Read-before-write: the output takes the old entry, the slot takes new y.
  always_comb begin
    buf_d = buf_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      x_d        = x;
      y_d        = buf_q[idx];
      buf_d[idx] = y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= 1'b0;
      y_q   <= 1'b0;
      buf_q <= BUF_INIT;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      buf_q <= buf_d;
    end
  end

  assign x_dec_r = x_q;
  assign y_dec_r = y_q;

`ifdef SEQ_DECORR_STATS_EN
  logic [15:0] in_cnt_q, out_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else if (en) begin
      if (y && (in_cnt_q != 16'hFFFF))           in_cnt_q  <= in_cnt_q + 16'd1;
      if (buf_q[idx] && (out_cnt_q != 16'hFFFF)) out_cnt_q <= out_cnt_q + 16'd1;
    end
  end

  assign ones_in_cnt  = in_cnt_q;
  assign ones_out_cnt = out_cnt_q;
`else
  // Statistics counters are not built; data path is unchanged.
`endif

endmodule

// File: tb/tb_seq_decorr.sv
// Self-checking bench for seq_decorr against a behavioural buffer/LFSR model.
module tb_seq_decorr;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic x = 1'b0;
  logic y = 1'b0;
  logic x_dec_r, y_dec_r;
`ifdef SEQ_DECORR_STATS_EN
  logic [15:0] ones_in_cnt, ones_out_cnt;
`endif

  seq_decorr #(.DEPTH(DEPTH), .SEED(8'h01)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .x       (x),
    .y       (y),
    .x_dec_r (x_dec_r),
`ifdef SEQ_DECORR_STATS_EN
    .y_dec_r      (y_dec_r),
    .ones_in_cnt  (ones_in_cnt),
    .ones_out_cnt (ones_out_cnt)
`else
    .y_dec_r (y_dec_r)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  int buf_m[DEPTH];
  int lfsr_m;
  int ones_in, ones_out_dut;
  logic exp_x, exp_y;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int next_lfsr(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) & 255) | fb;
  endfunction

  function automatic int model_pop();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += buf_m[i];
    return s;
  endfunction

  function automatic logic [DEPTH-1:0] model_buf();
    logic [DEPTH-1:0] b;
    for (int i = 0; i < DEPTH; i++) b[i] = (buf_m[i] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) buf_m[i] = i % 2;
    lfsr_m = 1;
    exp_x = 1'b0;
    exp_y = 1'b0;
    ones_in = 0;
    ones_out_dut = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic e, input logic xv, input logic yv);
    int idx;
    if (e) begin
      idx = lfsr_m % DEPTH;
      exp_y = (buf_m[idx] != 0);
      buf_m[idx] = yv ? 1 : 0;
      lfsr_m = next_lfsr(lfsr_m);
      exp_x = xv;
      ones_in += yv ? 1 : 0;
    end
    exp_q.push_back({exp_x, exp_y});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input logic xv, input logic yv);
    logic [1:0] exp;
    en = e;
    x = xv;
    y = yv;
    model_step(e, xv, yv);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    if (e && y_dec_r) ones_out_dut++;
    check("x_dec_r", x_dec_r, exp[1]);
    check("y_dec_r", y_dec_r, exp[0]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    x = 1'b0;
    y = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check("rst_x_dec_r", x_dec_r, 0);
    check("rst_y_dec_r", y_dec_r, 0);
    check("rst_lfsr", dut.lfsr_q, 32'h01);
    check("rst_buf", dut.buf_q, 32'hAA);
  endtask

  task automatic run_seq_test();
    int lt[5] = '{1, 2, 4, 8, 17};
    int yt[5] = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      check("seq_lfsr", dut.lfsr_q, lt[i]);
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      check("seq_y", y_dec_r, yt[i]);
    end
    check("seq_buf", dut.buf_q, 32'hA8);
  endtask

  function automatic real scc(input int a, input int b, input int c, input int d);
    real n, px, py, num, den;
    n = a + b + c + d;
    px = a + b;
    py = a + c;
    num = real'(a) * real'(d) - real'(b) * real'(c);
    if (num > 0.0) den = n * ((px < py) ? px : py) - px * py;
    else           den = px * py - n * (((px + py - n) > 0.0) ? (px + py - n) : 0.0);
    if (den == 0.0) return 0.0;
    return num / den;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic bits[256];
    int a, b, c, d, j;
    logic t;
    real s, sum_abs;

    // Reset state and the documented first five cycles.
    do_reset();
    run_seq_test();

    // Enable gap mid-stream: everything holds, resume with the same index.
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("hold_lfsr", dut.lfsr_q, lfsr_m);
      check("hold_buf", dut.buf_q, model_buf());
    end
    step(1'b1, 1'b1, 1'b1);
    check("resume_lfsr", dut.lfsr_q, lfsr_m);
    check("resume_buf", dut.buf_q, model_buf());

    // Random stream, y at p=0.75 with occasional idle cycles.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      check("conserve", ones_out_dut + model_pop(), ones_in + DEPTH / 2);
    end

    // Correlation: x and y carry the same balanced 256-bit stream.
    sum_abs = 0.0;
    for (int trial = 0; trial < 4; trial++) begin
      do_reset();
      for (int i = 0; i < 256; i++) bits[i] = (i < 128);
      for (int i = 255; i > 0; i--) begin
        j = $urandom_range(0, i);
        t = bits[i];
        bits[i] = bits[j];
        bits[j] = t;
      end
      a = 0; b = 0; c = 0; d = 0;
      for (int i = 0; i < 256; i++) begin
        step(1'b1, bits[i], bits[i]);
        if (x_dec_r && y_dec_r) a++;
        else if (x_dec_r) b++;
        else if (y_dec_r) c++;
        else d++;
      end
      s = scc(a, b, c, d);
      sum_abs += (s < 0.0) ? -s : s;
    end
    check("scc_small", ((sum_abs / 4.0) < 0.25), 1);

    // Asynchronous reset between clock edges after 37 cycles.
    do_reset();
    for (int i = 0; i < 36; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_x_dec_r", x_dec_r, 0);
    check("async_y_dec_r", y_dec_r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_seq_test();

`ifdef SEQ_DECORR_STATS_EN
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
    check("ones_in_cnt", ones_in_cnt, 20);
    check("ones_out_cnt", ones_out_cnt, 20 - (model_pop() - 4));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
